// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between instruction fetch and data requesters,
// data first, with a starvation counter that forces a fetch grant after MAX_DATA_BURST data grants.
module sram_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int CW = $clog2(MAX_DATA_BURST + 1);

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

    state_t        state_q;
    logic [CW-1:0] starve_q;
    logic          is_load_q;
    logic          sat, gnt_d, gnt_i;

    assign sat   = starve_q == CW'(MAX_DATA_BURST);
    assign gnt_d = !reset && data_req && !(inst_req && sat);
    assign gnt_i = !reset && !gnt_d && inst_req;

    assign inst_addr_ok = gnt_i;
    assign data_addr_ok = gnt_d;
    assign sram_en      = gnt_d || gnt_i;
    assign sram_wen     = (gnt_d && data_wr) ? data_wstrb : 4'b0;
    assign sram_addr    = gnt_d ? data_addr : gnt_i ? inst_addr : '0;
    assign sram_wdata   = gnt_d ? data_wdata : '0;

    // reset also masks a response still registered from the previous cycle
    assign inst_data_ok = !reset && state_q == RESP_I;
    assign data_data_ok = !reset && state_q == RESP_D;
    assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
    assign data_rdata   = (data_data_ok && is_load_q) ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= gnt_d ? RESP_D : gnt_i ? RESP_I : IDLE;
            is_load_q <= gnt_d && !data_wr;
            // every path other than a data grant under fetch pressure clears the count
            starve_q  <= (gnt_d && inst_req) ? (sat ? starve_q : starve_q + CW'(1)) : '0;
        end
    end
endmodule
